// File: rtl/bus_arbiter6.sv
// Round-robin arbiter for the six-source 16-bit internal bus.
// Registers a one-hot grant and mux select; a hold limit bounds each owner's tenure.
module bus_arbiter6 #(
  parameter int unsigned N_REQ    = 6,
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] select,
  output logic             bus_valid,
  output logic             timeout
);

  localparam int unsigned HoldW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  // With no limit the counter simply saturates at its all-ones value.
  localparam logic [HoldW-1:0] HoldMax =
      (MAX_HOLD > 0) ? HoldW'(MAX_HOLD) : {HoldW{1'b1}};
  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(N_REQ - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] select_q, select_d;
  logic             bus_valid_q, bus_valid_d;
  logic             timeout_q, timeout_d;

  logic             limit_hit;
  logic             release_bus;
  logic             load;
  logic [SEL_W-1:0] ptr_arb;
  logic [SEL_W-1:0] cand;
  logic [SEL_W-1:0] win_idx;
  logic             win_found;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    return (v == LastIdx) ? '0 : v + SEL_W'(1);
  endfunction

  assign limit_hit   = (MAX_HOLD != 0) && (hold_q == HoldMax);
  assign release_bus = done | ~req[select_q] | limit_hit;

  // On release the search already starts from the post-release pointer, so the
  // next owner is granted at the same edge and the old owner comes last.
  assign ptr_arb = (state_q == StGrant) ? wrap_inc(select_q) : ptr_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_arb;
    cand      = ptr_arb;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_d     = grant_q;
    select_d    = select_q;
    bus_valid_d = bus_valid_q;
    timeout_d   = 1'b0;
    load        = 1'b0;

    case (state_q)
      StIdle: begin
        if (win_found) begin
          load = 1'b1;
        end
      end
      StGrant: begin
        if (release_bus) begin
          ptr_d     = wrap_inc(select_q);
          timeout_d = limit_hit & ~done & req[select_q];
          if (win_found) begin
            load = 1'b1;
          end else begin
            state_d     = StIdle;
            grant_d     = '0;
            bus_valid_d = 1'b0;
            hold_d      = '0;
          end
        end else if (hold_q != HoldMax) begin
          hold_d = hold_q + HoldW'(1);
        end
      end
      default: begin
        state_d     = StIdle;
        grant_d     = '0;
        bus_valid_d = 1'b0;
      end
    endcase

    if (load) begin
      state_d     = StGrant;
      grant_d     = {{(N_REQ - 1){1'b0}}, 1'b1} << win_idx;
      select_d    = win_idx;
      bus_valid_d = 1'b1;
      hold_d      = HoldW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      hold_q      <= '0;
      grant_q     <= '0;
      select_q    <= '0;
      bus_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant_q     <= grant_d;
      select_q    <= select_d;
      bus_valid_q <= bus_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant     = grant_q;
  assign select    = select_q;
  assign bus_valid = bus_valid_q;
  assign timeout   = timeout_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));
  a_grant_matches: assert property (@(posedge clk) disable iff (reset)
                                    grant_q[select_q] == bus_valid_q);
  a_select_range:  assert property (@(posedge clk) disable iff (reset) select_q <= LastIdx);

endmodule
